block_xfer_uop_seq: RTL
=======================

// Module: block_xfer_uop_seq
// PURPOSE
//  Decode-stage micro-op sequencer and successor to the combinational decoder.
//  It cracks LDM/STM block transfers into one word-transfer micro-op per listed register.
//  All other instructions pass through unchanged as a single micro-op.
//  It sits between the InstrD register and the control decoder, and stalls fetch/decode while cracking.
// PARAMETERS
//  NREGS  16  register-list width (instr[NREGS-1:0]); register index width RIW = $clog2(NREGS)
//  STEP   4   byte stride between consecutive transfers
//  OFFW   12  width of the signed offset field UopOffsetD
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  FlushD         in   1      synchronous flush of the decode stage
//  InstrD         in   32     instruction in decode
//  InstrValidD    in   1      InstrD valid
//  InstrReadyD    out  1      instruction accepted this cycle; low = stall fetch/decode
//  UopReadyD      in   1      downstream accepts the current micro-op
//  UopValidD      out  1      micro-op valid (registered)
//  UopKindD       out  2      00 PASS, 01 MEM, 10 WB, 11 reserved
//  UopInstrD      out  32     originating instruction, held for the whole sequence
//  UopRdD         out  RIW    transfer register (MEM)
//  UopRnD         out  RIW    base register
//  UopOffsetD     out  OFFW   signed byte offset from the original Rn
//  UopLoadD       out  1      instr[20] for MEM micro-ops
//  UopPCWriteD    out  1      MEM load with Rd==15
//  UopFirstD      out  1      first micro-op of the instruction
//  UopLastD       out  1      last micro-op of the instruction
//  UopWbReqD      out  1      W bit pending (only when the macro is absent)
// BEHAVIOUR
//  Block transfer = instr[27:25]==3'b100. P=instr[24], U=instr[23], W=instr[21], L=instr[20].
//  Reset: state IDLE. All outputs 0, except InstrReadyD=1.
//  Output register: loads when !UopValidD || UopReadyD. Otherwise it holds every field stable.
//  InstrReadyD = (state==IDLE) && (!UopValidD || UopReadyD).
//  Latency: first micro-op appears 1 cycle after acceptance. Each further micro-op follows 1 cycle after the previous one is accepted.
//  FSM IDLE:
//   - accept non-block instruction -> PASS micro-op, First=Last=1, stay IDLE
//   - accept block instruction, n=popcount(list)>0 -> emit lowest register, go XFER (or stay IDLE if n==1 and no WB)
//   - accept block instruction, list==0 -> no micro-op, consumed as NOP, stay IDLE
//  FSM XFER: on UopReadyD, emit the next set bit in ascending order.
//   - after the last register -> WB (macro and W set) else IDLE
//  FSM WB: emit WB micro-op, then IDLE.
//  Offset of the k-th transfer (k=0..n-1), S=STEP, mod 2^OFFW:
//   - IA (P0 U1): k*S
//   - IB (P1 U1): (k+1)*S
//   - DA (P0 U0): (k-n+1)*S
//   - DB (P1 U0): (k-n)*S
//  Remaining list: bit cleared on each emission. Empty remaining list = final MEM micro-op.
//  FlushD: at the next edge state->IDLE, UopValidD->0, pending list cleared. Flush beats a simultaneous accept.
//  Reset asserted mid-sequence: immediate return to reset values. No partial micro-op is emitted after release.
// CONFIGURATION
//  BASE_WB_UOP_EN defined:
//   - W=1 appends a WB micro-op with UopOffsetD = U ? n*S : -n*S, UopLastD on WB
//   - UopWbReqD tied 0
//  BASE_WB_UOP_EN undefined:
//   - no WB state
//   - UopWbReqD=W on the last MEM micro-op; downstream performs the writeback
// STRUCTURE
//  Package uop_pkg:
//   - UOP_PASS/UOP_MEM/UOP_WB kind constants
//   - state encodings IDLE/XFER/WB
//   - BLOCK_XFER_OP = 3'b100
//  Sub-module reglist_scan (combinational):
//   - lowest set index
//   - one-hot clear mask
//   - popcount of NREGS-bit list
// TESTING
//  1. LDMIA R0,{R1,R3,R7}, UopReadyD=1 -> 3 MEM micro-ops.
//     - Rd 1,3,7; offsets 0,4,8
//     - First on #1, Last on #3; InstrReadyD low for 2 cycles
//  2. STMDB R13!,{R4,R5,R6,R14}, macro defined -> offsets -16,-12,-8,-4, then WB offset -16 with Last.
//     - macro undefined: 4 micro-ops, UopWbReqD=1 on #4
//  3. LDMIB R2,{R0,R15} with UopReadyD low 3 cycles after #1 -> #1 (Rd0, off 4) held stable.
//     - then Rd15, off 8, UopPCWriteD=1
//  4. FlushD in the cycle after #2 of a 5-register LDM -> UopValidD=0 next cycle.
//     - InstrReadyD=1; the next ADD passes as a PASS micro-op
//  5. reset low mid-sequence -> all outputs 0 asynchronously, state IDLE.
//     - empty-list LDM -> no micro-op, InstrReadyD stays 1
//  6. ADD/LDR stream of 4, UopReadyD=1 -> 4 PASS micro-ops, one per cycle, First=Last=1.

Source files
------------

// File: rtl/uop_pkg.sv
// ============================================================================
// Module : uop_pkg
// Brief  : Shared micro-op kind codes, sequencer state encodings and opcodes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uop_pkg;

   localparam logic [1:0] UOP_PASS = 2'b00;
   localparam logic [1:0] UOP_MEM  = 2'b01;
   localparam logic [1:0] UOP_WB   = 2'b10;

   localparam logic [2:0] BLOCK_XFER_OP = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2
   } seqState_t;

endpackage

`default_nettype wire

// File: rtl/reglist_scan.sv
// ============================================================================
// Module : reglist_scan
// Brief  : Lowest set index, its one-hot clear mask and popcount of a list.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reglist_scan #(
   parameter int NREGS = 16,
   localparam int RIW  = $clog2(NREGS),
   localparam int CW   = RIW + 1
) (
   input  logic [NREGS-1:0] regList,
   output logic [RIW-1:0]   lowIdx,
   output logic [NREGS-1:0] clearMask,
   output logic [CW-1:0]    popCnt
);

   always_comb begin
      lowIdx    = '0;
      clearMask = '0;
      popCnt    = '0;
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (regList[i]) begin
            lowIdx       = RIW'(i);
            clearMask    = '0;
            clearMask[i] = 1'b1;
         end
      end
      for (int i = 0; i < NREGS; i++) begin
         popCnt = popCnt + CW'(regList[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/block_xfer_uop_seq.sv
// ============================================================================
// Module : block_xfer_uop_seq
// Brief  : Decode-stage sequencer cracking LDM/STM into per-register micro-ops.
//          Optional macro BASE_WB_UOP_EN appends a base-writeback micro-op.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module block_xfer_uop_seq
   import uop_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int STEP  = 4,
   parameter int OFFW  = 12,
   localparam int RIW  = $clog2(NREGS),
   localparam int CW   = RIW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            FlushD,
   input  logic [31:0]     InstrD,
   input  logic            InstrValidD,
   output logic            InstrReadyD,
   input  logic            UopReadyD,
   output logic            UopValidD,
   output logic [1:0]      UopKindD,
   output logic [31:0]     UopInstrD,
   output logic [RIW-1:0]  UopRdD,
   output logic [RIW-1:0]  UopRnD,
   output logic [OFFW-1:0] UopOffsetD,
   output logic            UopLoadD,
   output logic            UopPCWriteD,
   output logic            UopFirstD,
   output logic            UopLastD,
   output logic            UopWbReqD
);

   seqState_t         r_state;
   logic [NREGS-1:0]  r_remList;
   logic [CW-1:0]     r_k;
   logic [CW-1:0]     r_n;

   seqState_t         w_nxtState;
   logic [NREGS-1:0]  w_nxtRem;
   logic [CW-1:0]     w_nxtK;
   logic [CW-1:0]     w_nxtN;
   logic              w_nxtValid;
   logic [1:0]        w_nxtKind;
   logic [31:0]       w_nxtInstr;
   logic [RIW-1:0]    w_nxtRd;
   logic [RIW-1:0]    w_nxtRn;
   logic [OFFW-1:0]   w_nxtOffset;
   logic              w_nxtLoad;
   logic              w_nxtPCWrite;
   logic              w_nxtFirst;
   logic              w_nxtLast;
   logic              w_nxtWbReq;

   logic              w_adv;
   logic              w_memEmit;
   logic [31:0]       w_memInstr;
   logic [NREGS-1:0]  w_scanList;
   logic [RIW-1:0]    w_lowIdx;
   logic [NREGS-1:0]  w_clearMask;
   logic [CW-1:0]     w_scanCnt;
   logic [NREGS-1:0]  w_rest;
   logic [CW-1:0]     w_k;
   logic [CW-1:0]     w_n;
   logic              w_lastXfer;
   logic              w_unused;

   assign w_unused = ^{InstrD[31:28], InstrD[22]};

   // Signed offsets wrap naturally in OFFW-bit arithmetic.
   function automatic logic [OFFW-1:0] xferOffset(input logic p, input logic u,
                                                  input logic [CW-1:0] k,
                                                  input logic [CW-1:0] n);
      logic [OFFW-1:0] kk;
      logic [OFFW-1:0] nn;
      logic [OFFW-1:0] idx;
      kk = OFFW'(k);
      nn = OFFW'(n);
      if (u) idx = p ? kk + OFFW'(1) : kk;
      else   idx = p ? kk - nn : kk - nn + OFFW'(1);
      return idx * OFFW'(STEP);
   endfunction

   assign w_adv       = !UopValidD || UopReadyD;
   assign InstrReadyD = (r_state == IDLE) && w_adv;

   assign w_memInstr = (r_state == IDLE) ? InstrD : UopInstrD;
   assign w_scanList = (r_state == IDLE) ? InstrD[NREGS-1:0] : r_remList;
   assign w_k        = (r_state == IDLE) ? '0 : r_k;
   assign w_n        = (r_state == IDLE) ? w_scanCnt : r_n;
   assign w_rest     = w_scanList & ~w_clearMask;
   assign w_lastXfer = (w_rest == '0);

   reglist_scan #(
      .NREGS     (NREGS)
   ) u_scan (
      .regList   (w_scanList),
      .lowIdx    (w_lowIdx),
      .clearMask (w_clearMask),
      .popCnt    (w_scanCnt)
   );

   always_comb begin
      w_nxtState   = r_state;
      w_nxtRem     = r_remList;
      w_nxtK       = r_k;
      w_nxtN       = r_n;
      w_nxtValid   = UopValidD;
      w_nxtKind    = UopKindD;
      w_nxtInstr   = UopInstrD;
      w_nxtRd      = UopRdD;
      w_nxtRn      = UopRnD;
      w_nxtOffset  = UopOffsetD;
      w_nxtLoad    = UopLoadD;
      w_nxtPCWrite = UopPCWriteD;
      w_nxtFirst   = UopFirstD;
      w_nxtLast    = UopLastD;
      w_nxtWbReq   = UopWbReqD;
      w_memEmit    = 1'b0;

      if (FlushD) begin
         w_nxtState = IDLE;
         w_nxtValid = 1'b0;
         w_nxtRem   = '0;
      end else if (w_adv) begin
         w_nxtValid = 1'b0;
         case (r_state)
            IDLE: begin
               if (InstrValidD) begin
                  if (InstrD[27:25] != BLOCK_XFER_OP) begin
                     w_nxtValid   = 1'b1;
                     w_nxtKind    = UOP_PASS;
                     w_nxtInstr   = InstrD;
                     w_nxtRd      = '0;
                     w_nxtRn      = '0;
                     w_nxtOffset  = '0;
                     w_nxtLoad    = 1'b0;
                     w_nxtPCWrite = 1'b0;
                     w_nxtFirst   = 1'b1;
                     w_nxtLast    = 1'b1;
                     w_nxtWbReq   = 1'b0;
                  end else if (w_scanCnt != '0) begin
                     w_memEmit = 1'b1;
                  end
               end
            end
            XFER: w_memEmit = 1'b1;
`ifdef BASE_WB_UOP_EN
            WB: begin
               w_nxtValid   = 1'b1;
               w_nxtKind    = UOP_WB;
               w_nxtRd      = '0;
               w_nxtOffset  = UopInstrD[23] ? OFFW'(r_n) * OFFW'(STEP)
                                            : OFFW'(0) - OFFW'(r_n) * OFFW'(STEP);
               w_nxtLoad    = 1'b0;
               w_nxtPCWrite = 1'b0;
               w_nxtFirst   = 1'b0;
               w_nxtLast    = 1'b1;
               w_nxtWbReq   = 1'b0;
               w_nxtState   = IDLE;
            end
`endif
            default: w_nxtState = IDLE;
         endcase

         if (w_memEmit) begin
            w_nxtValid   = 1'b1;
            w_nxtKind    = UOP_MEM;
            w_nxtInstr   = w_memInstr;
            w_nxtRd      = w_lowIdx;
            w_nxtRn      = w_memInstr[16 +: RIW];
            w_nxtOffset  = xferOffset(w_memInstr[24], w_memInstr[23], w_k, w_n);
            w_nxtLoad    = w_memInstr[20];
            w_nxtPCWrite = w_memInstr[20] && (w_lowIdx == RIW'(15));
            w_nxtFirst   = (r_state == IDLE);
            w_nxtRem     = w_rest;
            w_nxtK       = w_k + CW'(1);
            w_nxtN       = w_n;
`ifdef BASE_WB_UOP_EN
            w_nxtLast    = w_lastXfer && !w_memInstr[21];
            w_nxtWbReq   = 1'b0;
            w_nxtState   = !w_lastXfer ? XFER : (w_memInstr[21] ? WB : IDLE);
`else
            w_nxtLast    = w_lastXfer;
            w_nxtWbReq   = w_lastXfer && w_memInstr[21];
            w_nxtState   = !w_lastXfer ? XFER : IDLE;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_remList   <= '0;
         r_k         <= '0;
         r_n         <= '0;
         UopValidD   <= 1'b0;
         UopKindD    <= '0;
         UopInstrD   <= '0;
         UopRdD      <= '0;
         UopRnD      <= '0;
         UopOffsetD  <= '0;
         UopLoadD    <= 1'b0;
         UopPCWriteD <= 1'b0;
         UopFirstD   <= 1'b0;
         UopLastD    <= 1'b0;
         UopWbReqD   <= 1'b0;
      end else begin
         r_state     <= w_nxtState;
         r_remList   <= w_nxtRem;
         r_k         <= w_nxtK;
         r_n         <= w_nxtN;
         UopValidD   <= w_nxtValid;
         UopKindD    <= w_nxtKind;
         UopInstrD   <= w_nxtInstr;
         UopRdD      <= w_nxtRd;
         UopRnD      <= w_nxtRn;
         UopOffsetD  <= w_nxtOffset;
         UopLoadD    <= w_nxtLoad;
         UopPCWriteD <= w_nxtPCWrite;
         UopFirstD   <= w_nxtFirst;
         UopLastD    <= w_nxtLast;
         UopWbReqD   <= w_nxtWbReq;
      end
   end

endmodule

`default_nettype wire
